uart_mult_byte_tx: RTL and testbench

- Packet-level UART transmitter. It serialises one fixed 14-byte frame (header 0x55, payload, tail 0xAA) on uart_txd at UART_BPS.
- It is the host-facing counterpart of the multi-byte UART receive/decode path. Its frames are byte-compatible with that decoder: dataA at byte 1, dataB low byte at byte 2, dataD at byte 6, dataC at bytes 11/12.
- Used for loopback, self-test and status readback of the DDS control words.

---
 rtl/uart_mult_byte_tx_pkg.sv | 55 +++++
 rtl/uart_mult_byte_tx_byte_tx.sv | 99 +++++++++
 rtl/uart_mult_byte_tx.sv | 151 +++++++++++++++
 tb/tb_uart_mult_byte_tx.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mult_byte_tx_pkg.sv
// uart_mult_byte_tx_pkg: framing constants and FSM encodings for the multi-byte UART link.
// Shared with the receive/decode path so that the frame layout is defined in one place.
//   FRAME_HEAD/FRAME_TAIL : first and last byte of every frame
//   DATA_NUM              : bytes per frame
//   IDX_*                 : frame byte index of each payload field (16-bit fields are low byte first)
//   frame_byte()          : byte value at a given frame index for a given payload
package uart_mult_byte_tx_pkg;

  localparam logic [7:0]  FRAME_HEAD = 8'h55;
  localparam logic [7:0]  FRAME_TAIL = 8'hAA;
  localparam int unsigned DATA_NUM   = 14;

  localparam int unsigned IDX_A = 1;
  localparam int unsigned IDX_B = 2;
  localparam int unsigned IDX_D = 6;
  localparam int unsigned IDX_C = 11;

  // Per-byte serialiser states.
  typedef enum logic [1:0] {
    BitIdle,
    BitStart,
    BitData,
    BitStop
  } bit_state_e;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    FrmIdle,
    FrmSend,
    FrmGap
  } frm_state_e;

  // Unlisted indices are padding and read as zero.
  function automatic logic [7:0] frame_byte(input logic [7:0]  idx,
                                            input logic [7:0]  data_a,
                                            input logic [15:0] data_b,
                                            input logic [7:0]  data_d,
                                            input logic [15:0] data_c);
    logic [7:0] res;
    res = 8'h00;
    case (idx)
      8'd0:               res = FRAME_HEAD;
      8'(IDX_A):          res = data_a;
      8'(IDX_B):          res = data_b[7:0];
      8'(IDX_B + 1):      res = data_b[15:8];
      8'(IDX_D):          res = data_d;
      8'(IDX_C):          res = data_c[7:0];
      8'(IDX_C + 1):      res = data_c[15:8];
      8'(DATA_NUM - 1):   res = FRAME_TAIL;
      default:            res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_mult_byte_tx_byte_tx.sv
// uart_byte_tx: serialises one byte as start bit, 8 data bits LSB first, one stop bit.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   byte_start         : load byte_data and begin a byte (honoured when idle or on the
//                        final clock of a stop bit, giving back-to-back bytes)
//   byte_data          : byte to send, sampled with byte_start
//   byte_done          : high during the final clock of the stop bit
//   txd                : registered serial line, idle high
module uart_byte_tx
  import uart_mult_byte_tx_pkg::*;
#(
  parameter int unsigned BPS_CNT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       byte_start,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       txd
);

  localparam logic [15:0] BpsLast = 16'(BPS_CNT - 1);

  bit_state_e  state_q, state_d;
  logic [15:0] bps_cnt_q, bps_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        wrap;

  always_comb begin
    state_d   = state_q;
    bps_cnt_d = 16'd0;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    byte_done = 1'b0;
    wrap      = (bps_cnt_q == BpsLast);

    if (state_q != BitIdle && !wrap) bps_cnt_d = bps_cnt_q + 16'd1;

    unique case (state_q)
      BitIdle:  txd_d = 1'b1;
      BitStart: begin
        if (wrap) begin
          state_d = BitData;
          txd_d   = shift_q[0];
        end
      end
      BitData: begin
        if (wrap) begin
          if (bit_idx_q == 3'd7) begin
            state_d = BitStop;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      BitStop: begin
        if (wrap) begin
          byte_done = 1'b1;
          state_d   = BitIdle;
          txd_d     = 1'b1;
        end
      end
      default: state_d = BitIdle;
    endcase

    // Loading on the stop bit's last clock lets the next start bit follow with no idle gap.
    if (byte_start && (state_q == BitIdle || byte_done)) begin
      state_d   = BitStart;
      shift_d   = byte_data;
      bit_idx_d = 3'd0;
      bps_cnt_d = 16'd0;
      txd_d     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= BitIdle;
      bps_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bps_cnt_q <= bps_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  assign txd = txd_q;

endmodule

// File: rtl/uart_mult_byte_tx.sv
// uart_mult_byte_tx: sends one fixed 14-byte frame (0x55, payload, 0xAA) per request.
//   sys_clk, sys_rst_n       : clock, asynchronous active-low reset
//   send_req                 : one-cycle frame request; payload is snapshotted when accepted
//   dataA, dataB, dataD, dataC : payload fields (see uart_mult_byte_tx_pkg for placement)
//   uart_txd                 : serial line, idle high, registered
//   pack_busy                : frame in progress
//   pack_done                : one-cycle pulse after the final stop bit
//   byte_cnt                 : index of the byte on the line
//   req_drop                 : one-cycle pulse when a request is ignored because busy
// Build option: define UART_TX_GAP_EN to insert STOP_GAP idle bit-times between bytes.
// The request is sampled on the same edge that drives the start bit, and a request
// sampled on the final stop edge chains the next frame with no idle bit.
module uart_mult_byte_tx
  import uart_mult_byte_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 115200,
  parameter int unsigned STOP_GAP = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        send_req,
  input  logic [7:0]  dataA,
  input  logic [15:0] dataB,
  input  logic [7:0]  dataD,
  input  logic [15:0] dataC,
  output logic        uart_txd,
  output logic        pack_busy,
  output logic        pack_done,
  output logic [7:0]  byte_cnt,
  output logic        req_drop
);

  localparam int unsigned BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam logic [15:0] GapLast  = 16'(STOP_GAP * BPS_CNT - 1);
  localparam logic [7:0]  LastByte = 8'(DATA_NUM - 1);

  frm_state_e  frm_state_q, frm_state_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]  data_a_q, data_a_d, data_d_q, data_d_d;
  logic [15:0] data_b_q, data_b_d, data_c_q, data_c_d;
  logic        pack_busy_q, pack_busy_d;
  logic        pack_done_q, pack_done_d;
  logic        req_drop_q, req_drop_d;
  logic        accept, byte_start, byte_done;
  logic [7:0]  byte_data;

  always_comb begin
    frm_state_d = frm_state_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    data_c_d    = data_c_q;
    data_d_d    = data_d_q;
    pack_done_d = 1'b0;
    accept      = 1'b0;
    byte_start  = 1'b0;

    unique case (frm_state_q)
      FrmIdle: accept = send_req;
      FrmSend: begin
        if (byte_done) begin
          if (byte_cnt_q == LastByte) begin
            pack_done_d = 1'b1;
            byte_cnt_d  = 8'd0;
            frm_state_d = FrmIdle;
            accept      = send_req;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
`ifdef UART_TX_GAP_EN
            frm_state_d = FrmGap;
            gap_cnt_d   = 16'd0;
`else
            byte_start  = 1'b1;
`endif
          end
        end
      end
      FrmGap: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d   = 16'd0;
          frm_state_d = FrmSend;
          byte_start  = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: frm_state_d = FrmIdle;
    endcase

    if (accept) begin
      data_a_d    = dataA;
      data_b_d    = dataB;
      data_c_d    = dataC;
      data_d_d    = dataD;
      byte_cnt_d  = 8'd0;
      frm_state_d = FrmSend;
      byte_start  = 1'b1;
    end

    // Next-state values, so a freshly accepted payload is used for byte 0 in the same cycle.
    byte_data   = frame_byte(byte_cnt_d, data_a_d, data_b_d, data_d_d, data_c_d);
    pack_busy_d = (frm_state_d != FrmIdle);
    req_drop_d  = send_req && pack_busy_q && !accept;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frm_state_q <= FrmIdle;
      byte_cnt_q  <= 8'd0;
      gap_cnt_q   <= 16'd0;
      data_a_q    <= 8'h00;
      data_b_q    <= 16'h0000;
      data_c_q    <= 16'h0000;
      data_d_q    <= 8'h00;
      pack_busy_q <= 1'b0;
      pack_done_q <= 1'b0;
      req_drop_q  <= 1'b0;
    end else begin
      frm_state_q <= frm_state_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      data_c_q    <= data_c_d;
      data_d_q    <= data_d_d;
      pack_busy_q <= pack_busy_d;
      pack_done_q <= pack_done_d;
      req_drop_q  <= req_drop_d;
    end
  end

  uart_byte_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_byte_tx (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .byte_start (byte_start),
    .byte_data  (byte_data),
    .byte_done  (byte_done),
    .txd        (uart_txd)
  );

  assign pack_busy = pack_busy_q;
  assign pack_done = pack_done_q;
  assign byte_cnt  = byte_cnt_q;
  assign req_drop  = req_drop_q;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// tb_uart_mult_byte_tx: random and directed frames decoded by a bench-side UART receiver and
// compared with the frame map; also covers request drop, chained frames and mid-frame reset.
// A reduced clock/baud ratio (10 clocks per bit) keeps run time short.
`timescale 1ns/1ps
module tb_uart_mult_byte_tx;

  localparam int unsigned ClkFreq = 1_000_000;
  localparam int unsigned Bps     = 100_000;
  localparam int unsigned B       = ClkFreq / Bps;
  localparam int unsigned StopGap = 2;
`ifdef UART_TX_GAP_EN
  localparam int unsigned GapBits = StopGap;
`else
  localparam int unsigned GapBits = 0;
`endif
  localparam int unsigned ByteClks  = (10 + GapBits) * B;
  localparam int unsigned FrameClks = (140 + 13 * GapBits) * B;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        send_req = 1'b0;
  logic [7:0]  dataA = 8'h00;
  logic [15:0] dataB = 16'h0000;
  logic [7:0]  dataD = 8'h00;
  logic [15:0] dataC = 16'h0000;
  logic        uart_txd, pack_busy, pack_done, req_drop;
  logic [7:0]  byte_cnt;

  uart_mult_byte_tx #(
    .CLK_FREQ (ClkFreq),
    .UART_BPS (Bps),
    .STOP_GAP (StopGap)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .send_req  (send_req),
    .dataA     (dataA),
    .dataB     (dataB),
    .dataD     (dataD),
    .dataC     (dataC),
    .uart_txd  (uart_txd),
    .pack_busy (pack_busy),
    .pack_done (pack_done),
    .byte_cnt  (byte_cnt),
    .req_drop  (req_drop)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned drop_cnt = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [7:0]  rx_q[$];
  int unsigned fall_q[$];
  logic [7:0]  exp_q[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (pack_done) done_cnt <= done_cnt + 1;
    if (req_drop)  drop_cnt <= drop_cnt + 1;
  end

  // Bench UART receiver: samples each bit at its centre.
  initial begin : rx_mon
    logic [7:0] rx_byte;
    forever begin
      @(negedge sys_clk);
      if (uart_txd === 1'b0) begin
        fall_q.push_back(cyc);
        repeat (B / 2) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge sys_clk);
          rx_byte[i] = uart_txd;
        end
        repeat (B) @(negedge sys_clk);
        rx_q.push_back(rx_byte);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame from the frame map.
  task automatic build_exp(input logic [7:0] a, input logic [15:0] b,
                           input logic [7:0] d, input logic [15:0] c);
    exp_q.delete();
    for (int i = 0; i < 14; i++) exp_q.push_back(8'h00);
    exp_q[0]  = 8'h55;
    exp_q[1]  = a;
    exp_q[2]  = b[7:0];
    exp_q[3]  = b[15:8];
    exp_q[6]  = d;
    exp_q[11] = c[7:0];
    exp_q[12] = c[15:8];
    exp_q[13] = 8'hAA;
  endtask

  task automatic send(input logic [7:0] a, input logic [15:0] b,
                      input logic [7:0] d, input logic [15:0] c);
    @(negedge sys_clk);
    dataA = a; dataB = b; dataD = d; dataC = c;
    send_req = 1'b1;
    @(negedge sys_clk);
    send_req = 1'b0;
  endtask

  task automatic wait_fall(output int unsigned t);
    int unsigned n = 0;
    while (uart_txd !== 1'b0 && n < 4 * B) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("txd_start_fall", 32'(uart_txd), 32'd0);
    t = cyc;
  endtask

  task automatic wait_done(output int unsigned t);
    int unsigned n = 0;
    while (pack_done !== 1'b1 && n < FrameClks + 4 * B) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("pack_done_seen", 32'(pack_done), 32'd1);
    t = cyc;
  endtask

  task automatic wait_until_cyc(input int unsigned target);
    int unsigned n = 0;
    while (cyc < target && n < 2 * FrameClks) begin
      @(negedge sys_clk);
      n++;
    end
  endtask

  // Compares the oldest 14 received bytes with exp_q and consumes them.
  task automatic check_frame(input string tag);
    int unsigned bad_gap = 0;
    check_eq({tag, " nbytes"}, 32'(rx_q.size() >= 14), 32'd1);
    for (int i = 0; i < 14; i++)
      if (i < rx_q.size()) check_eq($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    for (int i = 1; i < 14; i++)
      if (i < fall_q.size() && fall_q[i] - fall_q[i-1] != ByteClks) bad_gap++;
    check_eq({tag, " byte_spacing_errs"}, bad_gap, 32'd0);
    for (int i = 0; i < 14; i++) begin
      if (rx_q.size() > 0)   void'(rx_q.pop_front());
      if (fall_q.size() > 0) void'(fall_q.pop_front());
    end
  endtask

  initial begin : main
    int unsigned t_req, t0, t1, t2, base_done, base_drop;
    logic [7:0]  a, d;
    logic [15:0] b, c;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check_eq("rst_txd", 32'(uart_txd), 32'd1);
    check_eq("rst_busy", 32'(pack_busy), 32'd0);
    check_eq("rst_done", 32'(pack_done), 32'd0);
    check_eq("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    check_eq("rst_req_drop", 32'(req_drop), 32'd0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Directed frame
    build_exp(8'h12, 16'hBEEF, 8'h34, 16'h5678);
    base_done = done_cnt;
    @(negedge sys_clk);
    t_req = cyc;
    dataA = 8'h12; dataB = 16'hBEEF; dataD = 8'h34; dataC = 16'h5678;
    send_req = 1'b1;
    @(negedge sys_clk);
    send_req = 1'b0;
    check_eq("busy_after_accept", 32'(pack_busy), 32'd1);
    wait_fall(t0);
    check_eq("start_latency", t0 - t_req, 32'd1);
    wait_done(t1);
    check_eq("frame_len", t1 - t0, FrameClks);
    check_eq("busy_at_done", 32'(pack_busy), 32'd0);
    check_eq("byte_cnt_at_done", 32'(byte_cnt), 32'd0);
    @(negedge sys_clk);
    check_eq("done_pulse_width", 32'(pack_done), 32'd0);
    check_frame("directed");
    repeat (2) @(negedge sys_clk);
    #1;
    check_eq("directed_done_count", done_cnt - base_done, 32'd1);

    // Random frames
    for (int k = 0; k < 3; k++) begin
      a = 8'($urandom); b = 16'($urandom); d = 8'($urandom); c = 16'($urandom);
      build_exp(a, b, d, c);
      send(a, b, d, c);
      wait_fall(t0);
      wait_done(t1);
      check_eq($sformatf("rand%0d frame_len", k), t1 - t0, FrameClks);
      check_frame($sformatf("rand%0d", k));
      repeat ($urandom_range(1, 3 * B)) @(negedge sys_clk);
    end

    // Request while busy is dropped; snapshot is unaffected
    a = 8'($urandom); b = 16'($urandom); d = 8'($urandom); c = 16'($urandom);
    build_exp(a, b, d, c);
    send(a, b, d, c);
    wait_fall(t0);
    base_done = done_cnt;
    base_drop = drop_cnt;
    for (int n = 0; n < int'(FrameClks) && byte_cnt != 8'd5; n++) @(negedge sys_clk);
    check_eq("drop_byte_cnt5", 32'(byte_cnt), 32'd5);
    dataA = 8'hFF; dataB = 16'hFFFF; dataD = 8'hFF; dataC = 16'hFFFF;
    send_req = 1'b1;
    @(negedge sys_clk);
    send_req = 1'b0;
    check_eq("req_drop_pulse", 32'(req_drop), 32'd1);
    check_eq("busy_during_drop", 32'(pack_busy), 32'd1);
    @(negedge sys_clk);
    check_eq("req_drop_one_cycle", 32'(req_drop), 32'd0);
    wait_done(t1);
    check_eq("drop frame_len", t1 - t0, FrameClks);
    repeat (3 * B) @(negedge sys_clk);
    #1;
    check_eq("drop_done_count", done_cnt - base_done, 32'd1);
    check_eq("drop_count", drop_cnt - base_drop, 32'd1);
    check_frame("drop");

    // Request on the edge that ends a frame chains the next frame
    a = 8'($urandom); b = 16'($urandom); d = 8'($urandom); c = 16'($urandom);
    build_exp(a, b, d, c);
    send(a, b, d, c);
    wait_fall(t0);
    wait_until_cyc(t0 + FrameClks - 1);
    a = 8'($urandom); b = 16'($urandom); d = 8'($urandom); c = 16'($urandom);
    dataA = a; dataB = b; dataD = d; dataC = c;
    send_req = 1'b1;
    @(negedge sys_clk);
    send_req = 1'b0;
    t1 = cyc;
    check_eq("chain done1", 32'(pack_done), 32'd1);
    check_eq("chain frame1_len", t1 - t0, FrameClks);
    check_eq("chain txd_start2", 32'(uart_txd), 32'd0);
    check_eq("chain no_drop", 32'(req_drop), 32'd0);
    check_frame("chain1");
    build_exp(a, b, d, c);
    @(negedge sys_clk);
    wait_done(t2);
    check_eq("chain done_spacing", t2 - t1, FrameClks);
    check_frame("chain2");

    // Asynchronous reset during byte 7, bit 3
    a = 8'($urandom); b = 16'($urandom); d = 8'($urandom); c = 16'($urandom);
    send(a, b, d, c);
    wait_fall(t0);
    wait_until_cyc(t0 + 7 * ByteClks + 4 * B + B / 2);
    check_eq("rst_mid byte_cnt7", 32'(byte_cnt), 32'd7);
    check_eq("rst_mid txd_low_bit3", 32'(uart_txd), 32'd0);
    base_done = done_cnt;
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_eq("rst_mid txd", 32'(uart_txd), 32'd1);
    check_eq("rst_mid busy", 32'(pack_busy), 32'd0);
    check_eq("rst_mid byte_cnt", 32'(byte_cnt), 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (20 * B) @(negedge sys_clk);
    #1;
    check_eq("rst_mid no_done", done_cnt - base_done, 32'd0);
    check_eq("rst_mid idle_txd", 32'(uart_txd), 32'd1);
    rx_q.delete();
    fall_q.delete();
    a = 8'($urandom); b = 16'($urandom); d = 8'($urandom); c = 16'($urandom);
    build_exp(a, b, d, c);
    send(a, b, d, c);
    wait_fall(t0);
    wait_done(t1);
    check_eq("post_rst frame_len", t1 - t0, FrameClks);
    check_frame("post_rst");

    repeat (2 * B) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
